ucie_sb_tx_serializer: RTL and testbench

- Upstream stage of the UCIe sideband interface: takes parallel sideband packets from the link/packet layer and produces the source-synchronous serial SBTX_CLK/SBTX_DATA pair.
- Guarantees the interface timing rules: 800 MHz clock during packets, a clean low clock during idle, and at least a 32 UI gap between packets.
- Runs on a 1.6 GHz clk, where one UI equals 2 clk cycles.

---
 rtl/ucie_sb_tx_serializer.sv | 184 ++++++++++++++++++
 tb/tb_ucie_sb_tx_serializer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_sb_tx_serializer.sv
// ---------------------------------------------------------------------------
// ucie_sb_tx_serializer
//
// Turns parallel sideband packets into the source-synchronous SBTX_CLK /
// SBTX_DATA pair. clk runs at twice the sideband bit rate, so one UI is two
// clk cycles: phase 0 presents the bit with the clock low, phase 1 raises the
// clock with the data held. Every packet is followed by a gap of 2*GAP_UI
// clk cycles with clock and data low.
//
// Handshake: a packet is transferred when in_valid && in_ready at a clk
// posedge and flush is low. in_ready is a register equal to !buf_valid, so
// there is no same-cycle bypass; in_valid may be held while in_ready is low
// and in_data must stay stable until the transfer. A flush in the same cycle
// wins and the offered packet is not taken.
//
// Ports:
//   clk        core clock (2x sideband bit rate)
//   reset_n    asynchronous active-low reset
//   in_valid   upstream packet valid
//   in_ready   upstream ready (registered)
//   in_data    packet payload, bit 0 transmitted first
//   flush      synchronous abort of the shifting and the buffered packet
//   SBTX_CLK   serial sideband clock
//   SBTX_DATA  serial sideband data
//   busy       state != IDLE or the holding buffer is full
//   pkt_done   one-cycle pulse in the first gap cycle after a full packet
//   state_dbg  current FSM state (IDLE=0, SHIFT=1, GAP=2)
// ---------------------------------------------------------------------------
module ucie_sb_tx_serializer #(
   parameter int PKT_W  = 64,
   parameter int GAP_UI = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PKT_W-1:0] in_data,
   input  logic             flush,
   output logic             SBTX_CLK,
   output logic             SBTX_DATA,
   output logic             busy,
   output logic             pkt_done,
   output logic [1:0]       state_dbg
);

   localparam int BW = $clog2(PKT_W);
   localparam int GW = $clog2(2*GAP_UI+1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(2*GAP_UI);
   localparam logic [BW-1:0] LAST_BIT = BW'(PKT_W-1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state;
   logic             buf_valid;
   logic [PKT_W-1:0] buf_data;
   logic [PKT_W-1:0] shift_q;
   logic [BW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             phase;
   logic             done_pend;

   logic accept;
   logic gap_last;
   logic load;
   logic buf_valid_nx;

   assign state_dbg = state;

   // Helper decodes shared by the buffer and the FSM. accept and load are
   // mutually exclusive because in_ready mirrors !buf_valid.
   always_comb begin
      accept       = in_valid && in_ready && !flush;
      gap_last     = (gap_cnt <= GW'(1));
      load         = 1'b0;
      buf_valid_nx = buf_valid;
      if (!flush && buf_valid &&
          ((state == IDLE) || ((state == GAP) && gap_last)))
         load = 1'b1;
      if (flush)
         buf_valid_nx = 1'b0;
      else if (accept)
         buf_valid_nx = 1'b1;
      else if (load)
         buf_valid_nx = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         buf_valid <= 1'b0;
         buf_data  <= '0;
         shift_q   <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         phase     <= 1'b0;
         done_pend <= 1'b0;
         in_ready  <= 1'b1;
         SBTX_CLK  <= 1'b0;
         SBTX_DATA <= 1'b0;
         busy      <= 1'b0;
         pkt_done  <= 1'b0;
      end else begin
         buf_valid <= buf_valid_nx;
         in_ready  <= !buf_valid_nx;
         if (accept)
            buf_data <= in_data;

         pkt_done  <= 1'b0;
         done_pend <= 1'b0;

         // Loading can happen from IDLE or at gap expiry; the outputs of
         // this edge are still the low idle/gap levels set below.
         if (load) begin
            shift_q <= buf_data;
            bit_cnt <= '0;
            phase   <= 1'b0;
            state   <= SHIFT;
         end

         case (state)
            IDLE: begin
               SBTX_CLK  <= 1'b0;
               SBTX_DATA <= 1'b0;
               busy      <= load || buf_valid_nx;
            end

            SHIFT: begin
               busy <= 1'b1;
               if (flush) begin
                  // Abort: drop the clock/data now and still honour a
                  // full gap before anything else may be sent.
                  SBTX_CLK  <= 1'b0;
                  SBTX_DATA <= 1'b0;
                  gap_cnt   <= GAP_LOAD;
                  state     <= GAP;
               end else if (!phase) begin
                  SBTX_CLK  <= 1'b0;
                  SBTX_DATA <= shift_q[0];
                  phase     <= 1'b1;
               end else begin
                  SBTX_CLK  <= 1'b1;
                  SBTX_DATA <= shift_q[0];
                  phase     <= 1'b0;
                  shift_q   <= shift_q >> 1;
                  if (bit_cnt == LAST_BIT) begin
                     gap_cnt   <= GAP_LOAD;
                     done_pend <= 1'b1;
                     state     <= GAP;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end

            GAP: begin
               SBTX_CLK  <= 1'b0;
               SBTX_DATA <= 1'b0;
               // done_pend lands pkt_done in the first gap cycle only.
               pkt_done  <= done_pend;
               if (gap_last) begin
                  if (!load)
                     state <= IDLE;
                  busy <= load || buf_valid_nx;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
                  busy    <= 1'b1;
               end
            end

            default: begin
               SBTX_CLK  <= 1'b0;
               SBTX_DATA <= 1'b0;
               busy      <= buf_valid_nx;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ucie_sb_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_ucie_sb_tx_serializer
//
// Bench for ucie_sb_tx_serializer: a default instance (PKT_W=64, GAP_UI=32)
// and an override instance (PKT_W=32, GAP_UI=40). A serial monitor per
// instance rebuilds packets from SBTX_CLK rising edges and compares them with
// the expected queue filled by the drivers. Outputs are sampled 1 time unit
// after the falling clk edge; cyc equals the number of the last rising edge.
// ---------------------------------------------------------------------------
module tb_ucie_sb_tx_serializer;

   localparam int W  = 64;
   localparam int W2 = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          reset_n;
   logic          in_valid, in_ready, flush, sb_clk, sb_data, busy, pkt_done;
   logic [W-1:0]  in_data;
   logic [1:0]    state_dbg;
   logic          in_valid2, in_ready2, flush2, sb_clk2, sb_data2, busy2, pkt_done2;
   logic [W2-1:0] in_data2;
   logic [1:0]    state_dbg2;

   ucie_sb_tx_serializer #(.PKT_W(W), .GAP_UI(32)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .flush(flush), .SBTX_CLK(sb_clk), .SBTX_DATA(sb_data),
      .busy(busy), .pkt_done(pkt_done), .state_dbg(state_dbg)
   );

   ucie_sb_tx_serializer #(.PKT_W(W2), .GAP_UI(40)) dut2 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_data(in_data2), .flush(flush2), .SBTX_CLK(sb_clk2), .SBTX_DATA(sb_data2),
      .busy(busy2), .pkt_done(pkt_done2), .state_dbg(state_dbg2)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) wait_neg();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || busy2) && n < 1000) begin
         wait_neg();
         n++;
      end
      if (busy || busy2) fail_now("idle_timeout");
   endtask

   // ---------------- scoreboard / monitor, instance 1 ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] rx_bits;
   int rx_cnt = 0, low_run = 0, both_low_run = 0, last_low_run = 0;
   int first_low_run = 0, first_pos = 0, last_pos = 0, prev_end = 0, pkts_rx = 0;
   logic prev_clk = 1'b0, prev_data = 1'b0;

   always @(negedge clk) begin
      if (!reset_n) begin
         rx_cnt = 0; low_run = 0; both_low_run = 0;
         prev_clk = 1'b0; prev_data = 1'b0;
      end else begin
         if (sb_clk && !prev_clk) begin
            check("data_hold", sb_data, prev_data);
            if (rx_cnt == 0) begin
               first_pos     = cyc;
               first_low_run = last_low_run;
            end else begin
               check("posedge_spacing", cyc - last_pos, 2);
            end
            last_pos        = cyc;
            rx_bits[rx_cnt] = sb_data;
            rx_cnt++;
            if (rx_cnt == W) begin
               if (exp_q.size() == 0) fail_now("unexpected_packet");
               else check("packet_data", rx_bits, exp_q.pop_front());
               pkts_rx++;
               prev_end = cyc;
               rx_cnt   = 0;
            end
         end
         if (!sb_clk) low_run++; else low_run = 0;
         if (low_run >= 3) rx_cnt = 0;
         if (!sb_clk && !sb_data) both_low_run++;
         else begin
            if (both_low_run > 0) last_low_run = both_low_run;
            both_low_run = 0;
         end
         prev_clk  = sb_clk;
         prev_data = sb_data;
      end
   end

   // ---------------- scoreboard / monitor, instance 2 ----------------
   logic [W2-1:0] exp2_q[$];
   logic [W2-1:0] rx2_bits;
   int rx2_cnt = 0, low2_run = 0, both2_run = 0, last2_run = 0, first2_low_run = 0;
   int pos2 = 0, pkts2 = 0, done2 = 0;
   logic prev_clk2 = 1'b0;

   always @(negedge clk) begin
      if (!reset_n) begin
         rx2_cnt = 0; low2_run = 0; both2_run = 0; prev_clk2 = 1'b0;
      end else begin
         if (pkt_done2) done2++;
         if (sb_clk2 && !prev_clk2) begin
            if (rx2_cnt == 0) first2_low_run = last2_run;
            pos2++;
            rx2_bits[rx2_cnt] = sb_data2;
            rx2_cnt++;
            if (rx2_cnt == W2) begin
               if (exp2_q.size() == 0) fail_now("unexpected_packet2");
               else check("packet_data2", rx2_bits, exp2_q.pop_front());
               pkts2++;
               rx2_cnt = 0;
            end
         end
         if (!sb_clk2) low2_run++; else low2_run = 0;
         if (low2_run >= 3) rx2_cnt = 0;
         if (!sb_clk2 && !sb_data2) both2_run++;
         else begin
            if (both2_run > 0) last2_run = both2_run;
            both2_run = 0;
         end
         prev_clk2 = sb_clk2;
      end
   end

   // ---------------- drivers ----------------
   // Offers d until accepted; acc is the rising-edge number of the transfer.
   task automatic send(input logic [W-1:0] d, output int acc);
      int budget = 0;
      acc      = -1;
      in_valid = 1'b1;
      in_data  = d;
      while (acc < 0 && budget < 400) begin
         if (in_ready && !flush) begin
            @(posedge clk);
            exp_q.push_back(d);
            wait_neg();
            acc = cyc;
         end else begin
            wait_neg();
            budget++;
         end
      end
      in_valid = 1'b0;
      if (acc < 0) fail_now("send_timeout");
   endtask

   task automatic send2(input logic [W2-1:0] d);
      int budget = 0;
      bit done   = 0;
      in_valid2 = 1'b1;
      in_data2  = d;
      while (!done && budget < 400) begin
         if (in_ready2) begin
            @(posedge clk);
            exp2_q.push_back(d);
            wait_neg();
            done = 1;
         end else begin
            wait_neg();
            budget++;
         end
      end
      in_valid2 = 1'b0;
      if (!done) fail_now("send2_timeout");
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [W-1:0] data;
      int           delay;
      logic         exp_bit0;
      int           exp_done_off;
      int           exp_idle_off;
   } vec_t;

   vec_t vecs[6];

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      fail_now("watchdog");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int acc, a1, a2, a3, base, p1_end, f, bad, n;
      logic [W-1:0] r;

      r = {$urandom(), $urandom()};
      vecs[0] = '{64'hA5A5_0000_FFFF_1234, 3, 1'b0, 130, 194};
      vecs[1] = '{64'h0000_0000_0000_0000, 0, 1'b0, 130, 194};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, 130, 194};
      vecs[3] = '{64'h8000_0000_0000_0001, 5, 1'b1, 130, 194};
      vecs[4] = '{64'h0123_4567_89AB_CDEF, 2, 1'b1, 130, 194};
      vecs[5] = '{r, $urandom_range(0, 7), r[0], 130, 194};

      reset_n = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
      in_valid2 = 1'b0; in_data2 = '0; flush2 = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) wait_neg();
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_sbtx_clk", sb_clk, 1'b0);
      check("reset_sbtx_data", sb_data, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_pkt_done", pkt_done, 1'b0);
      check("reset_state", state_dbg, 2'd0);
      reset_n = 1'b1;
      repeat (2) wait_neg();
      check("post_reset_in_ready", in_ready, 1'b1);

      // Table-driven single packets from idle.
      for (int i = 0; i < 6; i++) begin
         wait_idle();
         repeat (vecs[i].delay) wait_neg();
         base = pkts_rx;
         send(vecs[i].data, acc);
         wait_until(acc + 2);
         check("first_bit", sb_data, vecs[i].exp_bit0);
         check("first_bit_clk_low", sb_clk, 1'b0);
         wait_until(acc + 3);
         check("first_posedge", sb_clk, 1'b1);
         wait_until(acc + 129);
         check("last_posedge", sb_clk, 1'b1);
         check("no_early_done", pkt_done, 1'b0);
         wait_until(acc + vecs[i].exp_done_off);
         check("pkt_done", pkt_done, 1'b1);
         check("pkts_received", pkts_rx, base + 1);
         wait_until(acc + vecs[i].exp_done_off + 1);
         check("pkt_done_pulse", pkt_done, 1'b0);
         wait_until(acc + vecs[i].exp_idle_off - 2);
         check("busy_in_gap", busy, 1'b1);
         wait_until(acc + vecs[i].exp_idle_off);
         check("busy_idle", busy, 1'b0);
         check("ready_idle", in_ready, 1'b1);
         check("state_idle", state_dbg, 2'd0);
      end

      // Back-to-back: P2 offered while P1 shifts.
      wait_idle();
      base = pkts_rx;
      send(64'h1, a1);
      repeat (10) wait_neg();
      send(64'hFFFF_FFFF_FFFF_FFFF, a2);
      check("ready_drop", in_ready, 1'b0);
      wait_until(a1 + 130);
      p1_end = prev_end;
      wait_until(a1 + 322);
      check("b2b_pkts", pkts_rx, base + 2);
      check("b2b_spacing", first_pos - p1_end, 66);
      check("b2b_gap_low", first_low_run, 64);

      // Three packets offered continuously.
      wait_idle();
      base = pkts_rx;
      send(64'h1111_2222_3333_4444, a1);
      send(64'h5555_6666_7777_8888, a2);
      send(64'h9999_AAAA_BBBB_CCCC, a3);
      check("p2_accept", a2 - a1, 2);
      check("p3_stall", a3 - a1, 194);
      wait_until(a1 + 520);
      check("three_pkts", pkts_rx, base + 3);
      check("three_queue_empty", exp_q.size(), 0);

      // flush at bit 20 with a packet buffered.
      wait_idle();
      base = pkts_rx;
      send(64'hCAFE_F00D_1357_2468, a1);
      send(64'h0F0F_0F0F_0F0F_0F0F, a2);
      n = 0;
      while (rx_cnt != 20 && n < 200) begin wait_neg(); n++; end
      if (rx_cnt != 20) fail_now("flush_bit20_timeout");
      flush = 1'b1;
      wait_neg();
      flush = 1'b0;
      f = cyc;
      exp_q.delete();
      check("flush_clk_low", sb_clk, 1'b0);
      check("flush_data_low", sb_data, 1'b0);
      check("flush_no_done", pkt_done, 1'b0);
      check("flush_ready", in_ready, 1'b1);
      check("flush_busy", busy, 1'b1);
      bad = 0;
      for (int k = 1; k <= 64; k++) begin
         wait_neg();
         if (sb_clk || sb_data || pkt_done) bad++;
         if (k == 63) check("flush_gap_busy", busy, 1'b1);
      end
      check("flush_gap_quiet", bad, 0);
      check("flush_gap_end", cyc, f + 64);
      check("flush_idle", busy, 1'b0);
      check("flush_no_packet", pkts_rx, base);

      // Reset in the middle of a packet.
      wait_idle();
      send(64'hDEAD_BEEF_0BAD_F00D, a1);
      n = 0;
      while (rx_cnt != 40 && n < 200) begin wait_neg(); n++; end
      if (rx_cnt != 40) fail_now("reset_bit40_timeout");
      check("pre_reset_clk_high", sb_clk, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check("async_reset_clk", sb_clk, 1'b0);
      check("async_reset_data", sb_data, 1'b0);
      check("async_reset_ready", in_ready, 1'b1);
      check("async_reset_busy", busy, 1'b0);
      exp_q.delete();
      repeat (3) wait_neg();
      reset_n = 1'b1;
      wait_neg();
      base = pkts_rx;
      send(64'h0000_FFFF_0000_FFFF, a1);
      wait_until(a1 + 131);
      check("post_reset_pkt", pkts_rx, base + 1);
      check("post_reset_queue", exp_q.size(), 0);

      // Override instance: PKT_W=32, GAP_UI=40.
      wait_idle();
      send2(32'hDEAD_BEEF);
      send2(32'hFFFF_0001);
      n = 0;
      while (pkts2 < 2 && n < 800) begin wait_neg(); n++; end
      repeat (2) wait_neg();
      check("w32_pkts", pkts2, 2);
      check("w32_posedges", pos2, 64);
      check("w32_done_count", done2, 2);
      check("w32_gap_low", first2_low_run, 80);
      check("w32_queue_empty", exp2_q.size(), 0);

      wait_idle();
      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
